fifo_drain_mac: RTL and testbench

//  Downstream consumer of the parallel-read FIFO. Pops PAR_READ-word beats, forms a signed dot

---
 rtl/mac_pkg.sv | 21 ++
 rtl/dot_product_unit.sv | 32 +++
 rtl/fifo_drain_mac.sv | 154 +++++++++++++++
 tb/tb_fifo_drain_mac.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types, default dimensions and helpers for the FIFO-drain MAC datapath.
package mac_pkg;

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_e;

    localparam int unsigned DEF_SIZE     = 16;
    localparam int unsigned DEF_PAR_READ = 4;
    localparam int unsigned DEF_BEATS    = 8;
    localparam int unsigned DEF_ACC_SIZE = 40;
    localparam int unsigned MAX_W        = 128;
    localparam int unsigned MAX_IW       = $clog2(MAX_W);

    // Replicates bit [width-1] of val into every bit above it.
    function automatic logic [MAX_W-1:0] sign_extend(input logic [MAX_W-1:0] val,
                                                     input int unsigned     width);
        logic [MAX_W-1:0] mask;
        mask = {MAX_W{1'b1}} << width;
        return val[MAX_IW'(width - 1)] ? (val | mask) : (val & ~mask);
    endfunction

endpackage

// File: rtl/dot_product_unit.sv
// Combinational PAR_READ-lane signed multiply and sum; each 2*SIZE-bit product is
// sign-extended to ACC_SIZE bits before being added.
module dot_product_unit
    import mac_pkg::*;
#(
    parameter int unsigned SIZE     = DEF_SIZE,
    parameter int unsigned PAR_READ = DEF_PAR_READ,
    parameter int unsigned ACC_SIZE = DEF_ACC_SIZE
) (
    input  logic [SIZE*PAR_READ-1:0] data,
    input  logic [SIZE*PAR_READ-1:0] coef,
    output logic [ACC_SIZE-1:0]      dot
);

    localparam int unsigned PW = 2 * SIZE;

    logic signed [PW-1:0] prod [PAR_READ];

    always_comb begin
        for (int unsigned i = 0; i < PAR_READ; i++) begin
            prod[i] = PW'($signed(data[i*SIZE +: SIZE])) * PW'($signed(coef[i*SIZE +: SIZE]));
        end
    end

    always_comb begin
        dot = '0;
        for (int unsigned i = 0; i < PAR_READ; i++) begin
            dot = dot + ACC_SIZE'(sign_extend({{(MAX_W - PW){1'b0}}, prod[i]}, PW));
        end
    end

endmodule

// File: rtl/fifo_drain_mac.sv
// Drains PAR_READ-word beats from a show-ahead FIFO and accumulates BEATS signed dot products
// per frame. Define SATURATE_EN for saturating accumulation and a sticky sat_flag output.
module fifo_drain_mac
    import mac_pkg::*;
#(
    parameter int unsigned SIZE     = DEF_SIZE,
    parameter int unsigned PAR_READ = DEF_PAR_READ,
    parameter int unsigned BEATS    = DEF_BEATS,
    parameter int unsigned ACC_SIZE = DEF_ACC_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     fifo_empty,
    input  logic [SIZE*PAR_READ-1:0] fifo_dout,
    output logic                     fifo_ren,
    input  logic [SIZE*PAR_READ-1:0] coef,
    output logic [ACC_SIZE-1:0]      res_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     busy
`ifdef SATURATE_EN
    ,
    output logic                     sat_flag
`endif
);

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef SATURATE_EN
    // Dot and running sum are kept wide enough to be exact before clamping.
    localparam int unsigned PROD_SUM_W = 2 * SIZE + $clog2(PAR_READ) + 1;
    localparam int unsigned SUM_W = ((ACC_SIZE > PROD_SUM_W) ? ACC_SIZE : PROD_SUM_W) + 1;
    localparam int unsigned DOT_W = SUM_W;
`else
    localparam int unsigned DOT_W = ACC_SIZE;
`endif

    state_e              state_q, state_d;
    logic [ACC_SIZE-1:0] acc_q, acc_d, acc_next;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [ACC_SIZE-1:0] res_data_q, res_data_d;
    logic                res_valid_q, res_valid_d;
    logic [DOT_W-1:0]    dot;

    dot_product_unit #(
        .SIZE    (SIZE),
        .PAR_READ(PAR_READ),
        .ACC_SIZE(DOT_W)
    ) u_dot (
        .data(fifo_dout),
        .coef(coef),
        .dot (dot)
    );

`ifdef SATURATE_EN
    logic signed [SUM_W-1:0] acc_sum, sum_max, sum_min;
    logic                    sat_hit, sat_q, sat_d;

    assign sum_max = {{(SUM_W - ACC_SIZE + 1){1'b0}}, {(ACC_SIZE - 1){1'b1}}};
    assign sum_min = {{(SUM_W - ACC_SIZE + 1){1'b1}}, {(ACC_SIZE - 1){1'b0}}};

    always_comb begin
        acc_sum  = SUM_W'(sign_extend(MAX_W'(acc_q), ACC_SIZE)) + dot;
        acc_next = acc_sum[ACC_SIZE-1:0];
        sat_hit  = 1'b0;
        if (acc_sum > sum_max) begin
            acc_next = sum_max[ACC_SIZE-1:0];
            sat_hit  = 1'b1;
        end else if (acc_sum < sum_min) begin
            acc_next = sum_min[ACC_SIZE-1:0];
            sat_hit  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    assign acc_next = acc_q + dot;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beat_cnt_d  = beat_cnt_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        fifo_ren    = 1'b0;
`ifdef SATURATE_EN
        sat_d       = sat_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    acc_d      = '0;
                    beat_cnt_d = '0;
`ifdef SATURATE_EN
                    sat_d      = 1'b0;
`endif
                end
            end
            RUN: begin
                fifo_ren = !fifo_empty;
                if (fifo_ren) begin
                    acc_d      = acc_next;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
`ifdef SATURATE_EN
                    sat_d      = sat_q | sat_hit;
`endif
                    if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d     = OUT;
                        res_data_d  = acc_next;
                        res_valid_d = 1'b1;
                    end
                end
            end
            OUT: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat_cnt_q  <= beat_cnt_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_drain_mac.sv
// Bench for fifo_drain_mac: queue-backed show-ahead FIFO, result scoreboard, plus a 32-bit
// accumulator instance for the overflow corner (sat_flag checked when SATURATE_EN is defined).
module tb_fifo_drain_mac;

    localparam int unsigned SIZE  = 16;
    localparam int unsigned PR    = 4;
    localparam int unsigned BEATS = 8;
    localparam int unsigned ACC   = 40;
    localparam int unsigned W     = SIZE * PR;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           fifo_empty = 1'b1;
    logic [W-1:0]   fifo_dout = '0;
    logic           fifo_ren;
    logic [W-1:0]   coef = '0;
    logic [ACC-1:0] res_data;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic           busy;

    logic           o_start = 1'b0;
    logic           o_ren, o_valid, o_busy;
    logic           o_ready = 1'b0;
    logic [W-1:0]   o_word;
    logic [31:0]    o_data;
`ifdef SATURATE_EN
    logic           sat_flag, o_sat;
`endif

    logic [W-1:0]   fq [$];
    logic [ACC-1:0] exp_q [$];
    int             vectors = 0;
    int             miscompares = 0;
    int             pops = 0;
    int             o_pops = 0;
    int             ncyc = 0;
    int             first_pop = -1;
    int             rv_cyc = -1;
    bit             pop_pending = 1'b0;
    bit             o_pop_pending = 1'b0;

    logic signed [SIZE-1:0] cv2 [PR] = '{-16'sd1, 16'sd2, -16'sd3, 16'sd4};
    logic signed [SIZE-1:0] wv2 [PR] = '{16'sd100, -16'sd50, 16'sd7, -16'sd8};

    assign o_word = {PR{16'h8000}};

    always #5 clk = ~clk;

    fifo_drain_mac #(.SIZE(SIZE), .PAR_READ(PR), .BEATS(BEATS), .ACC_SIZE(ACC)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_ren  (fifo_ren),
        .coef      (coef),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
`ifdef SATURATE_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    fifo_drain_mac #(.SIZE(SIZE), .PAR_READ(PR), .BEATS(BEATS), .ACC_SIZE(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .start     (o_start),
        .fifo_empty(1'b0),
        .fifo_dout (o_word),
        .fifo_ren  (o_ren),
        .coef      (o_word),
        .res_data  (o_data),
        .res_valid (o_valid),
        .res_ready (o_ready),
        .busy      (o_busy)
`ifdef SATURATE_EN
        ,
        .sat_flag  (o_sat)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : {PR{16'h5A5A}};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle monitor: handshake/pop decisions seen here are what the next edge acts on.
    always @(negedge clk) begin
        ncyc++;
        pop_pending   = fifo_ren;
        o_pop_pending = o_ren;
        if (!rst) begin
            if (fifo_ren) begin
                check("ren_while_empty", 64'(fifo_empty), 64'd0);
                if (first_pop < 0) first_pop = ncyc;
            end
            if (res_valid && rv_cyc < 0) rv_cyc = ncyc;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: got res_data=0x%0h, required none", res_data);
                end else begin
                    check("res_data", 64'(res_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (pop_pending) begin
            pops++;
            if (fq.size() != 0) void'(fq.pop_front());
        end
        if (o_pop_pending) o_pops++;
        #1 refresh();
    end

    // mode: 0 random, 1 ones/twos, 2 fixed signed pattern, 3 all most-negative
    task automatic run_frame(input int mode, input int stall_at, input int stall_len, input int bp);
        logic signed [SIZE-1:0] cw [PR];
        logic signed [SIZE-1:0] w;
        logic [W-1:0]           beats [BEATS];
        logic [ACC-1:0]         exp;
        longint                 sum = 0;
        int                     base;
        for (int i = 0; i < PR; i++) begin
            case (mode)
                1:       cw[i] = 16'sd1;
                2:       cw[i] = cv2[i];
                3:       cw[i] = 16'sh8000;
                default: cw[i] = SIZE'($urandom);
            endcase
            coef[i*SIZE +: SIZE] = cw[i];
        end
        for (int b = 0; b < BEATS; b++) begin
            for (int i = 0; i < PR; i++) begin
                case (mode)
                    1:       w = 16'sd2;
                    2:       w = wv2[i];
                    3:       w = 16'sh8000;
                    default: w = SIZE'($urandom);
                endcase
                beats[b][i*SIZE +: SIZE] = w;
                sum += longint'(w) * longint'(cw[i]);
            end
        end
        exp = ACC'(sum);
        exp_q.push_back(exp);
        base      = pops;
        first_pop = -1;
        rv_cyc    = -1;
        for (int b = 0; b < BEATS; b++) begin
            if (stall_len == 0 || b < stall_at) fq.push_back(beats[b]);
        end
        refresh();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (stall_len > 0) begin
            for (int k = 0; k < 50 && pops != base + stall_at; k++) tick();
            for (int k = 0; k < stall_len; k++) tick();
            check("stall_pops", 64'(pops - base), 64'(stall_at));
            check("stall_busy", 64'(busy), 64'd1);
            for (int b = stall_at; b < BEATS; b++) fq.push_back(beats[b]);
            refresh();
        end
        for (int k = 0; k < 100 && !res_valid; k++) tick();
        if (!res_valid) begin
            check("res_valid_timeout", 64'(res_valid), 64'd1);
            void'(exp_q.pop_back());
            fq.delete();
            refresh();
            return;
        end
        if (bp > 0) begin
            fq.push_back(beats[0]);
            refresh();
            for (int k = 0; k < bp; k++) begin
                start = (k == bp / 2);
                tick();
                check("bp_valid", 64'(res_valid), 64'd1);
                check("bp_data", 64'(res_data), 64'(exp));
            end
            start = 1'b0;
            check("bp_no_pop", 64'(pops - base), 64'(BEATS));
            fq.delete();
            refresh();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("idle_after_hs", 64'(busy), 64'd0);
        check("valid_dropped", 64'(res_valid), 64'd0);
        check("data_held", 64'(res_data), 64'(exp));
        check("pop_count", 64'(pops - base), 64'(BEATS));
        if (stall_len == 0) check("latency", 64'(rv_cyc - first_pop), 64'(BEATS));
`ifdef SATURATE_EN
        check("no_sat", 64'(sat_flag), 64'd0);
`endif
    endtask

    task automatic reset_mid();
        for (int b = 0; b < BEATS; b++) fq.push_back(W'({$urandom, $urandom}));
        refresh();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ren", 64'(fifo_ren), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_data", 64'(res_data), 64'd0);
        tick();
        check("rst_ren_held", 64'(fifo_ren), 64'd0);
        rst = 1'b0;
        fq.delete();
        refresh();
        tick();
    endtask

    task automatic overflow();
        int base;
        base    = o_pops;
        o_start = 1'b1;
        tick();
        o_start = 1'b0;
        for (int k = 0; k < 100 && !o_valid; k++) tick();
        check("ovf_valid", 64'(o_valid), 64'd1);
`ifdef SATURATE_EN
        check("ovf_data", 64'(o_data), 64'h7FFF_FFFF);
        check("ovf_sat", 64'(o_sat), 64'd1);
`else
        check("ovf_data", 64'(o_data), 64'h0);
`endif
        check("ovf_pops", 64'(o_pops - base), 64'(BEATS));
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        check("ovf_idle", 64'(o_busy), 64'd0);
    endtask

    initial begin
        refresh();
        repeat (2) tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ren", 64'(fifo_ren), 64'd0);
        check("reset_valid", 64'(res_valid), 64'd0);
        check("reset_data", 64'(res_data), 64'd0);
`ifdef SATURATE_EN
        check("reset_sat", 64'(sat_flag), 64'd0);
`endif
        rst = 1'b0;
        tick();
        run_frame(1, 0, 0, 0);
        run_frame(2, 0, 0, 0);
        run_frame(0, 3, 5, 0);
        run_frame(0, 0, 0, 10);
        reset_mid();
        for (int n = 0; n < 20; n++) begin
            run_frame(0, int'($urandom_range(1, BEATS - 1)),
                      ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 6)) : 0,
                      int'($urandom_range(0, 4)));
        end
        run_frame(3, 0, 0, 2);
        overflow();
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
